// File: rtl/csa_resolve_cpa_pkg.sv
// Shared types and sizing helpers for the chunked carry-propagate resolver.
//   cpa_state_t : FSM encoding (IDLE -> BUSY -> DONE -> IDLE)
//   nchunk()    : number of CHUNK-wide slices in a MAX-wide operand
//   idx_w()     : width of the slice counter, $clog2(NCHUNK)+1 bits
package csa_resolve_cpa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } cpa_state_t;

  function automatic int nchunk(input int max, input int chunk);
    return max / chunk;
  endfunction

  // The extra bit keeps the counter at least one bit wide when NCHUNK == 1.
  function automatic int idx_w(input int max, input int chunk);
    return $clog2(max / chunk) + 1;
  endfunction

endpackage

// File: rtl/csa_resolve_cpa_if.sv
// Handshake bundle between the CSA tree side, the resolver and the result consumer.
//   in_valid/in_ready/s_in/c_in : operand side, redundant (s, c) pair
//   out_valid/out_ready/sum/cout: result side
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. The producer holds valid and data stable until
// that edge; ready may be asserted or withdrawn freely and carries no data.
// master = producer/consumer environment, slave = the resolver.
interface csa_resolve_cpa_if #(
  parameter int MAX = 32
);
  logic           in_valid;
  logic           in_ready;
  logic [MAX-1:0] s_in;
  logic [MAX-1:0] c_in;
  logic           out_valid;
  logic           out_ready;
  logic [MAX-1:0] sum;
  logic           cout;

  modport master (
    output in_valid, s_in, c_in, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, s_in, c_in, out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/csa_resolve_cpa_chunk.sv
// Combinational CHUNK-bit ripple-carry adder used for one slice per cycle.
//   a, b : CHUNK-bit addends
//   cin  : carry in from the previous slice
//   s    : CHUNK-bit sum
//   cout : carry out of the slice's top bit
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module cpa_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);
  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    fulladder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  assign cout = c[CHUNK];
endmodule

// File: rtl/csa_resolve_cpa.sv
// Final carry-propagate stage after a CSA reduction tree. One (s, c) pair is
// captured per transaction and resolved to sum = (s + c) mod 2^MAX, CHUNK bits
// per cycle, so the carry chain is only CHUNK full adders deep.
//   clk, reset : clock, synchronous active-high reset
//   io (slave) : in_valid/in_ready/s_in/c_in and out_valid/out_ready/sum/cout
//   busy       : high whenever the FSM is not in IDLE
//   state_dbg  : current FSM state
// Timing: handshake edge ends cycle 0, BUSY for cycles 1..NCHUNK, out_valid
// from cycle NCHUNK+1; back-to-back transactions take NCHUNK+2 cycles.
module csa_resolve_cpa
  import csa_resolve_cpa_pkg::*;
#(
  parameter int MAX   = 32,
  parameter int CHUNK = 8
) (
  input  logic                clk,
  input  logic                reset,
  csa_resolve_cpa_if.slave    io,
  output logic                busy,
  output cpa_state_t          state_dbg
);
  localparam int NCHUNK = nchunk(MAX, CHUNK);
  localparam int IDX_W  = idx_w(MAX, CHUNK);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);

  if (MAX % CHUNK != 0) begin : g_bad_chunk
    $error("csa_resolve_cpa: MAX must be a multiple of CHUNK");
  end

  cpa_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [MAX-1:0]   s_q, c_q, sum_q;
  logic             carry_q, cout_q;

  logic [CHUNK-1:0] chunk_s;
  logic             chunk_co;

  // One adder, steered to the active slice by idx.
  cpa_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a    (s_q[idx_q*CHUNK +: CHUNK]),
    .b    (c_q[idx_q*CHUNK +: CHUNK]),
    .cin  (carry_q),
    .s    (chunk_s),
    .cout (chunk_co)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (io.in_valid)      state_d = BUSY;
      BUSY:    if (idx_q == IDX_LAST) state_d = DONE;
      DONE:    if (io.out_ready)     state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      s_q     <= '0;
      c_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (io.in_valid) begin
            s_q     <= io.s_in;
            c_q     <= io.c_in;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
          end
        end
        BUSY: begin
          sum_q[idx_q*CHUNK +: CHUNK] <= chunk_s;
          carry_q                     <= chunk_co;
          idx_q                       <= idx_q + 1'b1;
          if (idx_q == IDX_LAST) cout_q <= chunk_co;
        end
        default: ;
      endcase
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign io.sum       = sum_q;
  assign io.cout      = cout_q;
  assign busy         = (state_q != IDLE);
  assign state_dbg    = state_q;
endmodule

// File: tb/tb_csa_resolve_cpa.sv
// Bench for csa_resolve_cpa: two instances (CHUNK=8 and CHUNK=32, MAX=32),
// directed vector table, backpressure and mid-transaction reset sequences,
// a CSA-tree integration case and random operands against s + c.
module tb_csa_resolve_cpa;
  import csa_resolve_cpa_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  csa_resolve_cpa_if #(.MAX(32)) bus8 ();
  csa_resolve_cpa_if #(.MAX(32)) bus32 ();
  logic       busy8, busy32;
  cpa_state_t st8, st32;

  csa_resolve_cpa #(.MAX(32), .CHUNK(8)) u_dut8 (
    .clk (clk), .reset (reset), .io (bus8.slave), .busy (busy8), .state_dbg (st8)
  );
  csa_resolve_cpa #(.MAX(32), .CHUNK(32)) u_dut32 (
    .clk (clk), .reset (reset), .io (bus32.slave), .busy (busy32), .state_dbg (st32)
  );

  int checks = 0;
  int failures = 0;
  logic [32:0] exp_q[$];

  typedef struct {
    logic [31:0] s;
    logic [31:0] c;
    logic [31:0] sum;
    logic        cout;
  } vec_t;

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_in(input int sel, input logic v, input logic [31:0] s, input logic [31:0] c);
    if (sel == 8) begin bus8.in_valid = v; bus8.s_in = s; bus8.c_in = c; end
    else begin bus32.in_valid = v; bus32.s_in = s; bus32.c_in = c; end
  endtask

  task automatic drive_ordy(input int sel, input logic v);
    if (sel == 8) bus8.out_ready = v; else bus32.out_ready = v;
  endtask

  function automatic logic ov(input int sel);
    return (sel == 8) ? bus8.out_valid : bus32.out_valid;
  endfunction
  function automatic logic rdy(input int sel);
    return (sel == 8) ? bus8.in_ready : bus32.in_ready;
  endfunction
  function automatic logic [32:0] res(input int sel);
    return (sel == 8) ? {bus8.cout, bus8.sum} : {bus32.cout, bus32.sum};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; the expected result must already be on exp_q.
  task automatic run_txn(input int sel, input logic [31:0] s, input logic [31:0] c,
                         input int stall_max, input string name, output int lat);
    int n, k;
    logic [32:0] held, expv;
    bit stable;
    n = 0;
    while (!rdy(sel) && n < 50) begin tick(); n++; end
    check({name, "_in_ready"}, 33'(rdy(sel)), 33'd1);
    drive_in(sel, 1'b1, s, c);
    tick();
    drive_in(sel, 1'b0, 32'h0, 32'h0);
    lat = 0;
    while (!ov(sel) && lat < 64) begin tick(); lat++; end
    check({name, "_out_valid"}, 33'(ov(sel)), 33'd1);
    held = res(sel);
    stable = 1'b1;
    k = $urandom_range(0, stall_max);
    for (int i = 0; i < k; i++) begin
      tick();
      if (res(sel) !== held || !ov(sel) || rdy(sel)) stable = 1'b0;
    end
    check({name, "_stall_stable"}, 33'(stable), 33'd1);
    expv = exp_q.pop_front();
    check({name, "_result"}, res(sel), expv);
    drive_ordy(sel, 1'b1);
    tick();
    drive_ordy(sel, 1'b0);
  endtask

  vec_t vecs[7];
  int   lat;
  int   n;
  logic [31:0] rs, rc, a, b, d;
  logic [31:0] tq[$];
  logic [32:0] held;
  bit   quiet;

  initial begin
    vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
    vecs[2] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[3] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
    vecs[4] = '{32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0};
    vecs[5] = '{32'h00FF_00FF, 32'h0001_0001, 32'h0100_0100, 1'b0};
    vecs[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1};

    reset = 1'b1;
    drive_in(8, 1'b0, 32'h0, 32'h0);
    drive_in(32, 1'b0, 32'h0, 32'h0);
    drive_ordy(8, 1'b0);
    drive_ordy(32, 1'b0);
    repeat (3) tick();
    reset = 1'b0;
    for (int sel = 8; sel <= 32; sel += 24) begin
      check("reset_in_ready", 33'(rdy(sel)), 33'd1);
      check("reset_out_valid", 33'(ov(sel)), 33'd0);
      check("reset_result", res(sel), 33'd0);
    end
    check("reset_busy", {31'd0, busy8, busy32}, 33'd0);

    // Directed table on both widths; latency in edges after the handshake edge is NCHUNK.
    for (int sel = 8; sel <= 32; sel += 24) begin
      for (int i = 0; i < 7; i++) begin
        exp_q.push_back({vecs[i].cout, vecs[i].sum});
        run_txn(sel, vecs[i].s, vecs[i].c, 2, $sformatf("vec%0d_c%0d", i, sel), lat);
        check($sformatf("vec%0d_c%0d_latency", i, sel), 33'(lat), 33'(32 / sel));
      end
    end

    // Backpressure with a pending second operand held on in_valid.
    drive_in(8, 1'b1, 32'h0000_0010, 32'h0000_0020);
    tick();
    drive_in(8, 1'b1, 32'hAAAA_0000, 32'h0000_5555);
    n = 0;
    while (!ov(8) && n < 20) begin tick(); n++; end
    held = res(8);
    check("bp_first_result", held, 33'h0_0000_0030);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_result", res(8), held);
      check("bp_hold_flags", {31'd0, ov(8), rdy(8)}, 33'b10);
    end
    drive_ordy(8, 1'b1);
    tick();
    drive_ordy(8, 1'b0);
    check("bp_after_out_hs", {31'd0, rdy(8), busy8}, 33'b10);
    tick();
    drive_in(8, 1'b0, 32'h0, 32'h0);
    check("bp_second_accept", 33'(busy8), 33'd1);
    n = 0;
    while (!ov(8) && n < 20) begin tick(); n++; end
    check("bp_second_result", res(8), 33'h0_AAAA_5555);
    drive_ordy(8, 1'b1);
    tick();
    drive_ordy(8, 1'b0);

    // Reset asserted during the second BUSY cycle discards the transaction.
    drive_in(8, 1'b1, 32'h0101_0101, 32'h0000_0000);
    tick();
    drive_in(8, 1'b0, 32'h0, 32'h0);
    tick();
    check("rst_mid_busy_before", 33'(st8 == BUSY), 33'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_state", 33'(st8 == IDLE), 33'd1);
    check("rst_mid_flags", {31'd0, ov(8), rdy(8)}, 33'b01);
    check("rst_mid_result", res(8), 33'd0);
    drive_ordy(8, 1'b1);
    quiet = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ov(8) || busy8) quiet = 1'b0;
    end
    drive_ordy(8, 1'b0);
    check("rst_mid_no_output", 33'(quiet), 33'd1);

    // Seven operands of 0x10 reduced by a 3:2 CSA tree, then resolved here.
    tq = {};
    for (int i = 0; i < 7; i++) tq.push_back(32'h10);
    while (tq.size() > 2) begin
      a = tq.pop_front(); b = tq.pop_front(); d = tq.pop_front();
      tq.push_back(a ^ b ^ d);
      tq.push_back(((a & b) | (a & d) | (b & d)) << 1);
    end
    exp_q.push_back(33'h0_0000_0070);
    run_txn(8, tq[0], tq[1], 1, "tree7_3", lat);

    // Random operands against plain unsigned addition, random output stalls.
    for (int sel = 8; sel <= 32; sel += 24) begin
      for (int i = 0; i < 1000; i++) begin
        rs = $urandom();
        rc = (i % 4 == 0) ? ~rs + 32'($urandom_range(0, 2)) : $urandom();
        exp_q.push_back({1'b0, rs} + {1'b0, rc});
        run_txn(sel, rs, rc, 3, $sformatf("rand_c%0d", sel), lat);
        if (i % 100 == 0) check($sformatf("rand_c%0d_latency", sel), 33'(lat), 33'(32 / sel));
      end
    end

    check("scoreboard_empty", 33'(exp_q.size()), 33'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
